speaker_ctrl: RTL and testbench
===============================

SPEAKER_CTRL -- requirements
Module: speaker_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, 100 MHz system clock.
REQ-002 SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-003 SHALL have port note_div_left, input, 22, left tone period in clk cycles; 0 = silence.
REQ-004 SHALL have port note_div_right, input, 22, right tone period in clk cycles; 0 = silence.
REQ-005 SHALL have port volume, input, 3, amplitude select 0..7.
REQ-006 SHALL have port audio_mclk, output, 1, DAC master clock, clk/4.
REQ-007 SHALL have port audio_sck, output, 1, DAC serial bit clock, clk/16.
REQ-008 SHALL have port audio_lrck, output, 1, DAC word select, clk/512; low = left, high = right.
REQ-009 SHALL have port audio_sdin, output, 1, DAC serial data, left-justified, MSB first.

Function
REQ-010 SHALL run a free-running 9-bit frame counter fc, +1 per clk, wrapping 511->0.
REQ-011 SHALL drive audio_mclk = fc[1], audio_sck = fc[3] and audio_lrck = fc[8].
REQ-012 SHALL give each channel a 22-bit phase counter pc: +1 per clk; when pc >= div-1, pc <= 0 on the next clk.
REQ-013 SHALL hold a channel's pc at 0 and its sample at 0x0000 while div < 4 (includes 0).
REQ-014 SHALL register each div every clk and clear pc to 0 on the clk after the div value changes.
REQ-015 SHALL make the channel sample +A while pc < (div >> 1), else -A (16-bit two's complement).
REQ-016 SHALL map amplitude A from volume: 0->0x0000, 1->0x0400, 2->0x0800, 3->0x1000, 4->0x2000, 5->0x3000, 6->0x4000, 7->0x6000.
REQ-017 SHALL latch both channel samples into frame registers L/R on the clk where fc goes 511->0, and on no other clk.
REQ-018 SHALL drive audio_sdin = L[15 - fc[7:4]] while fc[8]=0, and R[15 - fc[7:4]] while fc[8]=1.
REQ-019 SHALL change audio_sdin only when fc[3:0] wraps to 0 (the falling edge of sck), with MSB aligned to the lrck edge.
REQ-020 SHALL ignore note or volume changes mid-frame in the serial stream until the next frame latch.
REQ-021 SHALL produce no glitch on mclk, sck or lrck: every output is a register bit or a function of register bits only.

Reset
REQ-022 SHALL, while rst_n=0, force fc, both pc, the registered divs, L and R to 0.
REQ-023 SHALL hold all outputs 0 during reset.
REQ-024 SHALL, after rst_n rises, start fc from 0, with the first lrck low half-frame carrying L=0x0000.
REQ-025 SHALL, when reset is asserted mid-frame, abort the frame immediately with no partial-word completion.

Configuration
REQ-026 SHALL, with macro SPEAKER_VOLUME_EN defined, set A per REQ-016 from the volume input.
REQ-027 SHALL, with SPEAKER_VOLUME_EN undefined, fix A at 0x2000; the volume port remains but is ignored.

Verification
REQ-028 SHALL cover: reset release -> outputs 0 at release; mclk period 4 clk, sck period 16 clk, lrck period 512 clk; first rising lrck at clk 256.
REQ-029 SHALL cover: note_div_left=227272, volume=4 -> left sample 0x2000 for 113636 clk then 0xE000 for 113636 clk; frames latched in the high phase serialize 0010_0000_0000_0000 in the lrck-low half.
REQ-030 SHALL cover: note_div_right=0 or 3 -> right half-frame all zeros; pc stays 0.
REQ-031 SHALL cover: div changed 191571->151515 mid-period -> pc=0 one clk later; new period 151515 clk from there.
REQ-032 SHALL cover: volume 0 -> all-zero words when SPEAKER_VOLUME_EN is defined; volume 0 -> 0x2000/0xE000 words when it is undefined.
REQ-033 SHALL cover: rst_n pulsed low at fc=300 -> all outputs 0 immediately; after release, fc restarts at 0 and L/R=0 until the next latch.

Source files
------------

// File: rtl/speaker_ctrl.sv
// Stereo square-wave tone generator feeding a left-justified serial DAC (mclk/sck/lrck/sdin).
// Build option: define SPEAKER_VOLUME_EN to take amplitude from the volume port; otherwise it is fixed at 0x2000.
module speaker_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [21:0] note_div_left,
    input  logic [21:0] note_div_right,
    input  logic [2:0]  volume,
    output logic        audio_mclk,
    output logic        audio_sck,
    output logic        audio_lrck,
    output logic        audio_sdin
);

    logic [8:0]  fc_q, fc_d;
    logic [21:0] div_l_q, div_l_d;
    logic [21:0] div_r_q, div_r_d;
    logic [21:0] pc_l_q, pc_l_d;
    logic [21:0] pc_r_q, pc_r_d;
    logic [15:0] l_q, l_d;
    logic [15:0] r_q, r_d;
    logic [15:0] amp;
    logic [15:0] samp_l, samp_r;
    logic [15:0] tx_word;

    // A new divider restarts the phase; divs below 4 park the counter at 0.
    function automatic logic [21:0] next_pc(input logic [21:0] div_in,
                                            input logic [21:0] div_reg,
                                            input logic [21:0] pc);
        if ((div_in != div_reg) || (div_reg < 22'd4) || (pc >= div_reg - 22'd1))
            return 22'd0;
        return pc + 22'd1;
    endfunction

    function automatic logic [15:0] tone_sample(input logic [21:0] div_reg,
                                                input logic [21:0] pc,
                                                input logic [15:0] a);
        if (div_reg < 22'd4)
            return 16'h0000;
        if (pc < (div_reg >> 1))
            return a;
        return 16'h0000 - a;
    endfunction

`ifdef SPEAKER_VOLUME_EN
    always_comb begin
        amp = 16'h0000;
        case (volume)
            3'd0: amp = 16'h0000;
            3'd1: amp = 16'h0400;
            3'd2: amp = 16'h0800;
            3'd3: amp = 16'h1000;
            3'd4: amp = 16'h2000;
            3'd5: amp = 16'h3000;
            3'd6: amp = 16'h4000;
            3'd7: amp = 16'h6000;
            default: amp = 16'h0000;
        endcase
    end
`else
    logic unused_volume;
    assign unused_volume = ^volume;
    always_comb begin
        amp = 16'h2000;
    end
`endif

    always_comb begin
        fc_d    = fc_q + 9'd1;
        div_l_d = note_div_left;
        div_r_d = note_div_right;
        pc_l_d  = next_pc(note_div_left, div_l_q, pc_l_q);
        pc_r_d  = next_pc(note_div_right, div_r_q, pc_r_q);
        samp_l  = tone_sample(div_l_q, pc_l_q, amp);
        samp_r  = tone_sample(div_r_q, pc_r_q, amp);
        l_d     = l_q;
        r_d     = r_q;
        // Samples enter the serial words only at the frame boundary.
        if (fc_q == 9'd511) begin
            l_d = samp_l;
            r_d = samp_r;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fc_q    <= 9'd0;
            div_l_q <= 22'd0;
            div_r_q <= 22'd0;
            pc_l_q  <= 22'd0;
            pc_r_q  <= 22'd0;
            l_q     <= 16'h0000;
            r_q     <= 16'h0000;
        end else begin
            fc_q    <= fc_d;
            div_l_q <= div_l_d;
            div_r_q <= div_r_d;
            pc_l_q  <= pc_l_d;
            pc_r_q  <= pc_r_d;
            l_q     <= l_d;
            r_q     <= r_d;
        end
    end

    assign audio_mclk = fc_q[1];
    assign audio_sck  = fc_q[3];
    assign audio_lrck = fc_q[8];

    // Bit index steps as fc[3:0] wraps, so sdin moves on the falling sck edge.
    always_comb begin
        tx_word    = fc_q[8] ? r_q : l_q;
        audio_sdin = tx_word[4'd15 - fc_q[7:4]];
    end

endmodule

// File: tb/tb_speaker_ctrl.sv
// Randomized bench for speaker_ctrl: a cycle-count/phase-age model predicts every output bit each clock.
// Honors SPEAKER_VOLUME_EN the same way as the design.
module tb_speaker_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [21:0] div_l = 22'd0;
    logic [21:0] div_r = 22'd0;
    logic [2:0]  vol = 3'd0;
    logic        mclk, sck, lrck, sdin;

    int n_tests = 0;
    int n_fail  = 0;

    speaker_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .note_div_left  (div_l),
        .note_div_right (div_r),
        .volume         (vol),
        .audio_mclk     (mclk),
        .audio_sck      (sck),
        .audio_lrck     (lrck),
        .audio_sdin     (sdin)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] amp_of(input logic [2:0] v);
`ifdef SPEAKER_VOLUME_EN
        logic [15:0] tbl [8];
        tbl = '{16'h0000, 16'h0400, 16'h0800, 16'h1000,
                16'h2000, 16'h3000, 16'h4000, 16'h6000};
        return tbl[v];
`else
        if (v > 3'd7) return 16'h0000;
        return 16'h2000;
`endif
    endfunction

    // Square wave as a function of cycles elapsed since the divider was adopted.
    function automatic logic [15:0] model_sample(input logic [21:0] d, input int unsigned age,
                                                 input logic [15:0] a);
        int unsigned dd;
        int unsigned ph;
        dd = {10'd0, d};
        if (dd < 4) return 16'h0000;
        ph = age % dd;
        if (ph < dd / 2) return a;
        return 16'h0000 - a;
    endfunction

    // Reference model: n = clock edges since reset release, k_* = edge when each divider was adopted.
    int unsigned n = 0;
    int unsigned k_l = 0;
    int unsigned k_r = 0;
    logic [21:0] mdiv_l = 22'd0;
    logic [21:0] mdiv_r = 22'd0;
    logic [15:0] m_l = 16'h0000;
    logic [15:0] m_r = 16'h0000;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n      <= 0;
            k_l    <= 0;
            k_r    <= 0;
            mdiv_l <= 22'd0;
            mdiv_r <= 22'd0;
            m_l    <= 16'h0000;
            m_r    <= 16'h0000;
        end else begin
            if ((n + 1) % 512 == 0) begin
                m_l <= model_sample(mdiv_l, n - k_l, amp_of(vol));
                m_r <= model_sample(mdiv_r, n - k_r, amp_of(vol));
            end
            n <= n + 1;
            if (div_l != mdiv_l) begin
                mdiv_l <= div_l;
                k_l    <= n + 1;
            end
            if (div_r != mdiv_r) begin
                mdiv_r <= div_r;
                k_r    <= n + 1;
            end
        end
    end

    always @(negedge clk) begin : out_chk
        logic [8:0]  fcm;
        logic [15:0] word;
        logic [3:0]  idx;
        fcm  = 9'(n % 512);
        word = fcm[8] ? m_r : m_l;
        idx  = 4'd15 - fcm[7:4];
        check("clocks", 32'({mclk, sck, lrck}), 32'({fcm[1], fcm[3], fcm[8]}));
        check("sdin", 32'(sdin), 32'(word[idx]));
    end

    task automatic run_cycles(input int c);
        repeat (c) @(negedge clk);
    endtask

    initial begin : stim
        bit found;
        rst_n = 1'b0;
        div_l = 22'd227272;
        div_r = 22'd0;
        vol   = 3'd4;
        run_cycles(3);
        check("rst_outs", 32'({mclk, sck, lrck, sdin}), 32'd0);
        #2 rst_n = 1'b1;

        // Long tone on the left: first half-period gives +A words; silent right.
        run_cycles(3 * 512);
        div_r = 22'd3;
        run_cycles(1024);
        // Mid-period divider change restarts the phase.
        div_l = 22'd191571;
        run_cycles(700);
        div_l = 22'd151515;
        run_cycles(1024);
        vol   = 3'd0;
        div_l = 22'd1000;
        div_r = 22'd777;
        run_cycles(1536);

        // Asynchronous reset in the middle of a frame.
        found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            @(negedge clk);
            if (n % 512 == 300) found = 1'b1;
        end
        check("fc300_reached", 32'(found), 32'd1);
        #2 rst_n = 1'b0;
        #1 check("rst_abort", 32'({mclk, sck, lrck, sdin}), 32'd0);
        run_cycles(3);
        #2 rst_n = 1'b1;
        run_cycles(1100);

        for (int s = 0; s < 40; s++) begin
            if ($urandom_range(0, 4) == 0) div_l = 22'($urandom_range(0, 5));
            else                           div_l = 22'($urandom_range(4, 3000));
            if ($urandom_range(0, 4) == 0) div_r = 22'($urandom_range(0, 5));
            else                           div_r = 22'($urandom_range(4, 3000));
            vol = 3'($urandom_range(0, 7));
            run_cycles($urandom_range(100, 1500));
        end
        run_cycles(600);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
